// File: rtl/cdb_arbiter_if.sv
// Handshake and broadcast bundle between the two result pipes, the ROB and
// the CDB arbiter. The arbiter uses the slave view; the environment
// (pipes, ROB, flush logic) uses the master view.
interface cdb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_BITS   = 1
);
  // ALU reservation-station pipe
  logic                  alu_valid;
  logic [TAG_BITS-1:0]   alu_tag;
  logic [DATA_WIDTH-1:0] alu_value;
  logic                  alu_ready;

  // Memory reservation-station pipe
  logic                  mem_valid;
  logic [TAG_BITS-1:0]   mem_tag;
  logic [DATA_WIDTH-1:0] mem_value;
  logic                  mem_ready;

  // ROB back-pressure and mispredict recovery
  logic                  cdb_stall;
  logic                  flush;

  // Registered broadcast
  logic                  cdb_valid;
  logic [TAG_BITS-1:0]   cdb_tag;
  logic [DATA_WIDTH-1:0] cdb_value;
  logic                  cdb_src;

  modport slave (
    input  alu_valid, alu_tag, alu_value,
    output alu_ready,
    input  mem_valid, mem_tag, mem_value,
    output mem_ready,
    input  cdb_stall, flush,
    output cdb_valid, cdb_tag, cdb_value, cdb_src
  );

  modport master (
    output alu_valid, alu_tag, alu_value,
    input  alu_ready,
    output mem_valid, mem_tag, mem_value,
    input  mem_ready,
    output cdb_stall, flush,
    input  cdb_valid, cdb_tag, cdb_value, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin choice between the ALU and memory
// result pipes, one registered broadcast per cycle, ROB back-pressure,
// mispredict flush and a saturating contention counter.
module cdb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_BITS   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cdb_arbiter_if.slave         bus,
  output logic [CNT_WIDTH-1:0] conflict_count
);

  // Which requester wins the next contended cycle.
  typedef enum logic {
    PREF_ALU = 1'b0,
    PREF_MEM = 1'b1
  } rr_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  rr_e                   rr_ptr_reg;
  logic                  cdb_valid_reg;
  logic [TAG_BITS-1:0]   cdb_tag_reg;
  logic [DATA_WIDTH-1:0] cdb_value_reg;
  logic                  cdb_src_reg;
  logic [CNT_WIDTH-1:0]  conflict_count_reg;

  logic accept;
  logic both_valid;
  logic grant_alu;
  logic grant_mem;

  // Slot availability and round-robin grant; readies are forced low in reset
  // so nothing is consumed that the register would then drop.
  always_comb begin
    accept     = !rst && !bus.flush && (!cdb_valid_reg || !bus.cdb_stall);
    both_valid = bus.alu_valid && bus.mem_valid;
    grant_alu  = 1'b0;
    grant_mem  = 1'b0;
    if (accept) begin
      if (both_valid) begin
        if (rr_ptr_reg == PREF_ALU) grant_alu = 1'b1;
        else                        grant_mem = 1'b1;
      end else begin
        grant_alu = bus.alu_valid;
        grant_mem = bus.mem_valid;
      end
    end
  end

  assign bus.alu_ready  = grant_alu;
  assign bus.mem_ready  = grant_mem;
  assign bus.cdb_valid  = cdb_valid_reg;
  assign bus.cdb_tag    = cdb_tag_reg;
  assign bus.cdb_value  = cdb_value_reg;
  assign bus.cdb_src    = cdb_src_reg;
  assign conflict_count = conflict_count_reg;

  // Broadcast register and fairness pointer; flush only drops the valid bit,
  // a stalled broadcast holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg    <= PREF_ALU;
      cdb_valid_reg <= 1'b0;
      cdb_tag_reg   <= '0;
      cdb_value_reg <= '0;
      cdb_src_reg   <= 1'b0;
    end else if (bus.flush) begin
      cdb_valid_reg <= 1'b0;
    end else if (accept) begin
      if (grant_alu) begin
        cdb_valid_reg <= 1'b1;
        cdb_tag_reg   <= bus.alu_tag;
        cdb_value_reg <= bus.alu_value;
        cdb_src_reg   <= 1'b0;
        rr_ptr_reg    <= PREF_MEM;
      end else if (grant_mem) begin
        cdb_valid_reg <= 1'b1;
        cdb_tag_reg   <= bus.mem_tag;
        cdb_value_reg <= bus.mem_value;
        cdb_src_reg   <= 1'b1;
        rr_ptr_reg    <= PREF_ALU;
      end else begin
        cdb_valid_reg <= 1'b0;
      end
    end
  end

  // Count cycles where both pipes compete for an open slot, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_count_reg <= '0;
    end else if (both_valid && accept && (conflict_count_reg != CNT_MAX)) begin
      conflict_count_reg <= conflict_count_reg + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_cdb_arbiter;

  localparam int DW      = 32;
  localparam int TB      = 1;
  localparam int CW      = 4;
  localparam int CNT_MAX = 15;

  logic          clk;
  logic          rst;
  logic [CW-1:0] conflict_count;

  cdb_arbiter_if #(.DATA_WIDTH(DW), .TAG_BITS(TB)) bus ();

  cdb_arbiter #(.DATA_WIDTH(DW), .TAG_BITS(TB), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .conflict_count (conflict_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: the broadcast slot, the preferred requester and the counter.
  logic          m_valid;
  logic [TB-1:0] m_tag;
  logic [DW-1:0] m_value;
  logic          m_src;
  logic          m_pref;   // 0: ALU wins next contention, 1: MEM wins
  int            m_cnt;

  // Readies observed from the DUT in the last cycle (used only to drive
  // the requesters' hold/advance behaviour).
  logic          seen_alu_ready;
  logic          seen_mem_ready;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check readies and current broadcast
  // against the model, then advance the model across the edge.
  task automatic do_cycle(input logic r,
                          input logic av, input logic [TB-1:0] at, input logic [DW-1:0] ad,
                          input logic mv, input logic [TB-1:0] mt, input logic [DW-1:0] md,
                          input logic st, input logic fl);
    logic open_slot, exp_a, exp_m;
    @(negedge clk);
    rst           = r;
    bus.alu_valid = av;
    bus.alu_tag   = at;
    bus.alu_value = ad;
    bus.mem_valid = mv;
    bus.mem_tag   = mt;
    bus.mem_value = md;
    bus.cdb_stall = st;
    bus.flush     = fl;
    #1;
    open_slot = !r && !fl && (!m_valid || !st);
    exp_a = 1'b0;
    exp_m = 1'b0;
    if (open_slot) begin
      if (av && mv) begin
        exp_a = (m_pref == 1'b0);
        exp_m = (m_pref == 1'b1);
      end else begin
        exp_a = av;
        exp_m = mv;
      end
    end
    check_eq("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
    if (m_valid) begin
      check_eq("cdb_tag",   64'(bus.cdb_tag),   64'(m_tag));
      check_eq("cdb_value", 64'(bus.cdb_value), 64'(m_value));
      check_eq("cdb_src",   64'(bus.cdb_src),   64'(m_src));
    end
    check_eq("conflict_count", 64'(conflict_count), 64'(m_cnt));
    check_eq("alu_ready", 64'(bus.alu_ready), 64'(exp_a));
    check_eq("mem_ready", 64'(bus.mem_ready), 64'(exp_m));
    seen_alu_ready = bus.alu_ready;
    seen_mem_ready = bus.mem_ready;
    if (exp_a) $display("cycle %0d: grant ALU tag=%0h value=%08h", cyc, at, ad);
    if (exp_m) $display("cycle %0d: grant MEM tag=%0h value=%08h", cyc, mt, md);
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      m_valid = 1'b0; m_tag = '0; m_value = '0; m_src = 1'b0;
      m_pref  = 1'b0; m_cnt = 0;
    end else begin
      if (open_slot && av && mv && m_cnt < CNT_MAX) m_cnt++;
      if (fl) begin
        m_valid = 1'b0;
      end else if (open_slot) begin
        if (exp_a) begin
          m_valid = 1'b1; m_tag = at; m_value = ad; m_src = 1'b0; m_pref = 1'b1;
        end else if (exp_m) begin
          m_valid = 1'b1; m_tag = mt; m_value = md; m_src = 1'b1; m_pref = 1'b0;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input logic r);
    do_cycle(r, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Random requester state: holds its request until accepted.
  logic          ra_v, rm_v;
  logic [TB-1:0] ra_t, rm_t;
  logic [DW-1:0] ra_d, rm_d;

  initial begin
    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_tag = '0; bus.alu_value = '0;
    bus.mem_valid = 1'b0; bus.mem_tag = '0; bus.mem_value = '0;
    bus.cdb_stall = 1'b0; bus.flush = 1'b0;
    m_valid = 1'b0; m_tag = '0; m_value = '0; m_src = 1'b0; m_pref = 1'b0; m_cnt = 0;
    seen_alu_ready = 1'b0; seen_mem_ready = 1'b0;

    // Reset, then idle
    idle(1'b1);
    idle(1'b1);
    check_eq("rst_valid", 64'(bus.cdb_valid), 64'd0);
    check_eq("rst_tag",   64'(bus.cdb_tag),   64'd0);
    check_eq("rst_value", 64'(bus.cdb_value), 64'd0);
    check_eq("rst_src",   64'(bus.cdb_src),   64'd0);
    check_eq("rst_count", 64'(conflict_count), 64'd0);
    for (int i = 0; i < 5; i++) idle(1'b0);

    // Single ALU request
    do_cycle(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("single_ready", 64'(seen_alu_ready), 64'd1);
    check_eq("single_valid", 64'(bus.cdb_valid), 64'd1);
    check_eq("single_tag",   64'(bus.cdb_tag),   64'd1);
    check_eq("single_value", 64'(bus.cdb_value), 64'hDEADBEEF);
    check_eq("single_src",   64'(bus.cdb_src),   64'd0);
    idle(1'b0);

    // Contention: ALU, MEM, ALU, MEM
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b0, 1'b1, TB'(i), $urandom, 1'b1, TB'(i + 1), $urandom, 1'b0, 1'b0);
      check_eq("rr_src", 64'(bus.cdb_src), 64'(i % 2));
    end
    check_eq("rr_count", 64'(conflict_count), 64'd4);

    // Back-pressure on a pending MEM broadcast
    idle(1'b1);
    do_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b1, 1'b1, 32'hA, 1'b0, '0, '0, 1'b1, 1'b0);
      check_eq("stall_alu_ready", 64'(seen_alu_ready), 64'd0);
      check_eq("stall_hold",      64'(bus.cdb_value),  64'h5);
    end
    do_cycle(1'b0, 1'b1, 1'b1, 32'hA, 1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("unstall_alu_ready", 64'(seen_alu_ready), 64'd1);
    check_eq("unstall_value",     64'(bus.cdb_value),  64'hA);
    check_eq("unstall_src",       64'(bus.cdb_src),    64'd0);

    // Flush while stalled with both valid; MEM should win the next contention
    do_cycle(1'b0, 1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 32'h22, 1'b1, 1'b1);
    check_eq("flush_alu_ready", 64'(seen_alu_ready), 64'd0);
    check_eq("flush_mem_ready", 64'(seen_mem_ready), 64'd0);
    check_eq("flush_valid",     64'(bus.cdb_valid),  64'd0);
    do_cycle(1'b0, 1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 32'h22, 1'b0, 1'b0);
    check_eq("flush_rr_src",   64'(bus.cdb_src),   64'd1);
    check_eq("flush_rr_value", 64'(bus.cdb_value), 64'h22);

    // Counter saturation
    idle(1'b1);
    for (int i = 0; i < 20; i++)
      do_cycle(1'b0, 1'b1, TB'(i), $urandom, 1'b1, TB'(i), $urandom, 1'b0, 1'b0);
    check_eq("sat_count", 64'(conflict_count), 64'd15);

    // Randomized traffic
    idle(1'b1);
    ra_v = 1'b0; rm_v = 1'b0; ra_t = '0; rm_t = '0; ra_d = '0; rm_d = '0;
    for (int i = 0; i < 400; i++) begin
      logic r_rst, r_st, r_fl;
      if (!ra_v) begin
        ra_v = ($urandom_range(0, 9) < 6);
        ra_t = TB'($urandom);
        ra_d = $urandom;
      end
      if (!rm_v) begin
        rm_v = ($urandom_range(0, 9) < 6);
        rm_t = TB'($urandom);
        rm_d = $urandom;
      end
      r_rst = ($urandom_range(0, 99) == 0);
      r_st  = ($urandom_range(0, 9) < 3);
      r_fl  = ($urandom_range(0, 19) == 0);
      do_cycle(r_rst, ra_v, ra_t, ra_d, rm_v, rm_t, rm_d, r_st, r_fl);
      if (ra_v && seen_alu_ready) ra_v = 1'b0;
      if (rm_v && seen_mem_ready) rm_v = 1'b0;
    end
    idle(1'b0);
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
